// File: rtl/gpio_irq.sv
// GPIO edge-interrupt block: per-pin 2-flop synchronizer, counter debounce, and a small
// register file (LEVEL / PENDING / ENABLE / POLARITY) with a level interrupt output.
module gpio_irq #(
   parameter int unsigned WIDHT           = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      address,
   input  logic [31:0]      write_data,
   output logic [31:0]      read_data,
   input  logic [WIDHT-1:0] gpio_in,
   output logic             irq
);

   localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {RegLevel, RegPending, RegEnable, RegPolarity} reg_sel_e;

   reg_sel_e         sel;
   logic [WIDHT-1:0] s1_q, s2_q;
   logic [WIDHT-1:0] db_q, db_d;
   logic [CntW-1:0]  cnt_q [WIDHT];
   logic [CntW-1:0]  cnt_d [WIDHT];
   logic [WIDHT-1:0] pending_q, pending_d;
   logic [WIDHT-1:0] enable_q, enable_d;
   logic [WIDHT-1:0] polarity_q, polarity_d;
   logic [WIDHT-1:0] set_evt, clr_mask, rd_reg;
   logic             unused_bus;

   assign sel = reg_sel_e'(address[3:2]);
   assign unused_bus = ^{address[31:4], address[1:0], write_data};

   // A pin's level is accepted once s2 has disagreed with db for DEBOUNCE_CYCLES edges in a row.
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < int'(WIDHT); i++) begin
         cnt_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               db_d[i] = s2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // POLARITY 0 flags a 0->1 change, 1 flags a 1->0 change.
   assign set_evt = (db_d ^ db_q) & (db_d ^ polarity_q);

   always_comb begin
      clr_mask   = '0;
      enable_d   = enable_q;
      polarity_d = polarity_q;
      if (write) begin
         unique case (sel)
            RegPending:  clr_mask   = write_data[WIDHT-1:0];
            RegEnable:   enable_d   = write_data[WIDHT-1:0];
            RegPolarity: polarity_d = write_data[WIDHT-1:0];
            default:     ;
         endcase
      end
      // A new event beats a same-cycle clear.
      pending_d = (pending_q & ~clr_mask) | set_evt;
   end

   always_comb begin
      rd_reg = '0;
      if (read) begin
         unique case (sel)
            RegLevel:    rd_reg = db_q;
            RegPending:  rd_reg = pending_q;
            RegEnable:   rd_reg = enable_q;
            RegPolarity: rd_reg = polarity_q;
            default:     rd_reg = '0;
         endcase
      end
      read_data = 32'(rd_reg);
   end

   assign irq = |(pending_q & enable_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_q       <= '0;
         s2_q       <= '0;
         db_q       <= '0;
         cnt_q      <= '{default: '0};
         pending_q  <= '0;
         enable_q   <= '0;
         polarity_q <= '0;
      end else begin
         s1_q       <= gpio_in;
         s2_q       <= s1_q;
         db_q       <= db_d;
         cnt_q      <= cnt_d;
         pending_q  <= pending_d;
         enable_q   <= enable_d;
         polarity_q <= polarity_d;
      end
   end

endmodule

// File: doc/gpio_irq.md
GPIO_IRQ -- requirements
Module: gpio_irq

Interface
REQ-001 The block SHALL have parameter WIDHT, default 5, giving the number of GPIO inputs monitored (1..32).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 4, giving the number of consecutive stable cycles required to accept a level change (2..255).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port read, input, 1 bit, the bus read strobe.
REQ-006 The block SHALL have port write, input, 1 bit, the bus write strobe, sampled on the rising edge of clk.
REQ-007 The block SHALL have port address, input, 32 bits, the bus address; only bits [3:2] are decoded.
REQ-008 The block SHALL have port write_data, input, 32 bits, the bus write data.
REQ-009 The block SHALL have port read_data, output, 32 bits, the bus read data.
REQ-010 The block SHALL have port gpio_in, input, WIDHT bits, the raw asynchronous pin levels from the GPIO pads.
REQ-011 The block SHALL have port irq, output, 1 bit, the level interrupt to the core.

Function
REQ-012 The register map SHALL be:
- 0x0 LEVEL: debounced levels, read-only.
- 0x4 PENDING: write-1-to-clear.
- 0x8 ENABLE: read/write.
- 0xC POLARITY: read/write; bit=0 selects rising edge, bit=1 selects falling edge.
REQ-013 Only bits [WIDHT-1:0] SHALL be stored; upper bits SHALL read 0; writes to LEVEL SHALL be ignored.
REQ-014 read_data SHALL be combinational: the selected register when read=1, else 32'h0.
REQ-015 Each pin SHALL pass through a 2-flop synchronizer (s1, s2) before debounce.
REQ-016 Per-pin debounce SHALL operate as follows on each edge:
- if s2 != db and cnt == DEBOUNCE_CYCLES-1: db<=s2 and cnt<=0;
- else if s2 != db: cnt<=cnt+1;
- else: cnt<=0.
REQ-017 A gpio_in change stable from before edge k SHALL update db at edge k+DEBOUNCE_CYCLES+1; pulses shorter than DEBOUNCE_CYCLES cycles at s2 SHALL never change db.
REQ-018 At the edge where db changes, PENDING[i] SHALL be set if the transition matches POLARITY[i], independent of ENABLE[i].
REQ-019 irq SHALL equal the OR over i of (PENDING[i] & ENABLE[i]), combinational from the registers; no extra latency.
REQ-020 A W1C write and a set event on the same bit in the same cycle SHALL leave the bit set (set wins); other bits clear normally.
REQ-021 Changing POLARITY or ENABLE SHALL NOT alter PENDING or debounce state.
REQ-022 Write and read asserted together SHALL perform the write; read_data SHALL show the pre-write value that cycle.

Reset
REQ-023 While reset=0, all of the following SHALL be 0 asynchronously: s1, s2, db, cnt, PENDING, ENABLE, POLARITY.
REQ-024 While reset=0, irq SHALL be 0 and read_data SHALL be 0.
REQ-025 Reset asserted mid-debounce SHALL discard the count; after release, a pin held high SHALL require a full DEBOUNCE_CYCLES+2 edges to reach db.
REQ-026 No pending event SHALL be generated by reset release itself; pins high at release produce a rising edge only after debounce.

Verification (WIDHT=5, DEBOUNCE_CYCLES=4)
REQ-027 Scenario 1: write ENABLE=0x15, then gpio_in[0] 0->1 held -> LEVEL=0x01 and PENDING=0x01 exactly 5 edges after the change, irq=1.
REQ-028 Scenario 2: gpio_in[2] high pulse of 2 cycles -> LEVEL, PENDING unchanged, irq stays 0.
REQ-029 Scenario 3: POLARITY=0x10, ENABLE=0x10, gpio_in[4] 0->1->0 (each held 8 cycles) -> PENDING[4] set only on the falling edge, irq=1; write PENDING=0x10 -> PENDING=0, irq=0 next cycle.
REQ-030 Scenario 4: ENABLE=0, event on pin 0 -> PENDING=0x01, irq=0; then write ENABLE=0x01 -> irq=1 immediately after the write edge.
REQ-031 Scenario 5: W1C of bit 0 on the same edge as a new pin-0 event -> PENDING[0] stays 1.
REQ-032 Scenario 6: reset=0 after 2 stable cycles of gpio_in=0x1F -> all registers 0, irq=0; after release, LEVEL=0x1F at edge 6, PENDING=0x1F.
